// File: rtl/mrd_fsm_source.sv
// Source-side reader for the mixed-radix DFT memory: replays one frame from the
// 7 RAM banks in sink order (bank 0..6 per address) as a valid/sop/eop stream.
module mrd_fsm_source #(
    parameter int wADDR  = 8,
    parameter int wDATA  = 32,
    parameter int RD_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2:0]           fsm,
    input  logic [11:0]          frame_len,
    output logic [wADDR-1:0]     rdaddr,
    output logic [6:0]           rden,
    input  logic [7*wDATA-1:0]   rddata,
    output logic                 out_valid,
    output logic                 out_sop,
    output logic                 out_eop,
    output logic [wDATA-1:0]     out_data,
    output logic                 source_done,
    output logic                 overTime
);

    localparam logic [2:0] SRC = 3'd5;

    typedef enum logic {ST_IDLE, ST_ISSUE} state_t;

    state_t             state;
    logic [2:0]         fsm_q;
    logic [11:0]        len_r;
    logic [11:0]        cnt;
    logic [2:0]         bank_idx;
    logic [wADDR-1:0]   addr;
    logic [11:0]        cnt_ot;

    logic [RD_LAT:0]    p_valid;
    logic [RD_LAT:0]    p_first;
    logic [RD_LAT:0]    p_last;
    logic [2:0]         p_bank [0:RD_LAT];

    logic               in_src;
    logic               start;
    logic               issue_fire;
    logic [wDATA-1:0]   sel_data;

    assign in_src     = (fsm == SRC);
    assign start      = in_src && (fsm_q != SRC);
    assign issue_fire = !start && (state == ST_ISSUE) && in_src && (len_r != 12'd0);

    // Pick the bank word that was addressed RD_LAT cycles ago; bank 0 sits in the top slice.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < 7; k++) begin
            if (p_bank[RD_LAT] == 3'(k)) begin
                sel_data = rddata[(6-k)*wDATA +: wDATA];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            fsm_q       <= '0;
            len_r       <= '0;
            cnt         <= '0;
            bank_idx    <= '0;
            addr        <= '0;
            cnt_ot      <= '0;
            rdaddr      <= '0;
            rden        <= '0;
            out_valid   <= 1'b0;
            out_sop     <= 1'b0;
            out_eop     <= 1'b0;
            out_data    <= '0;
            source_done <= 1'b0;
            overTime    <= 1'b0;
            p_valid     <= '0;
            p_first     <= '0;
            p_last      <= '0;
            for (int k = 0; k <= RD_LAT; k++) begin
                p_bank[k] <= '0;
            end
        end else begin
            fsm_q       <= fsm;
            cnt_ot      <= in_src ? cnt_ot + 12'd1 : 12'd0;
            overTime    <= (cnt_ot == 12'd2047);
            source_done <= in_src && out_valid && out_eop;
            rden        <= '0;

            if (start) begin
                len_r    <= frame_len;
                cnt      <= '0;
                bank_idx <= '0;
                addr     <= '0;
                state    <= ST_ISSUE;
            end else if (!in_src) begin
                state <= ST_IDLE;
            end else if (state == ST_ISSUE) begin
                if (len_r == 12'd0) begin
                    state       <= ST_IDLE;
                    source_done <= 1'b1;
                end else begin
                    rden   <= 7'b1000000 >> bank_idx;
                    rdaddr <= addr;
                    cnt    <= cnt + 12'd1;
                    if (bank_idx == 3'd6) begin
                        bank_idx <= '0;
                        addr     <= addr + wADDR'(1);
                    end else begin
                        bank_idx <= bank_idx + 3'd1;
                    end
                    if (cnt == len_r - 12'd1) begin
                        state <= ST_IDLE;
                    end
                end
            end

            // Issue tags travel alongside the RAM latency; leaving Source kills every stage at once.
            p_valid[0] <= issue_fire;
            p_first[0] <= (cnt == 12'd0);
            p_last[0]  <= (cnt == len_r - 12'd1);
            p_bank[0]  <= bank_idx;
            for (int k = 1; k <= RD_LAT; k++) begin
                p_valid[k] <= in_src && p_valid[k-1];
                p_first[k] <= p_first[k-1];
                p_last[k]  <= p_last[k-1];
                p_bank[k]  <= p_bank[k-1];
            end

            out_valid <= in_src && p_valid[RD_LAT];
            out_sop   <= in_src && p_valid[RD_LAT] && p_first[RD_LAT];
            out_eop   <= in_src && p_valid[RD_LAT] && p_last[RD_LAT];
            if (p_valid[RD_LAT]) begin
                out_data <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_mrd_fsm_source.sv
// Directed bench for mrd_fsm_source: a frame table plus abort, reset and
// timeout sequences against a 7-bank RAM model with two cycles of read latency.
module tb_mrd_fsm_source;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   fsm;
    logic [11:0]  frame_len;
    logic [7:0]   rdaddr;
    logic [6:0]   rden;
    logic [223:0] rddata;
    logic         out_valid, out_sop, out_eop, source_done, overTime;
    logic [31:0]  out_data;

    always #5 clk = ~clk;

    mrd_fsm_source #(.wADDR(8), .wDATA(32), .RD_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n), .fsm(fsm), .frame_len(frame_len),
        .rdaddr(rdaddr), .rden(rden), .rddata(rddata),
        .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
        .out_data(out_data), .source_done(source_done), .overTime(overTime)
    );

    // RAM model: address seen at the bank port in cycle t gives data in cycle t+2.
    logic [31:0] mem [7][256];
    logic [7:0]  addr_d1, addr_d2;

    always @(posedge clk) begin
        addr_d1 <= rdaddr;
        addr_d2 <= addr_d1;
    end

    always_comb begin
        rddata = '0;
        for (int k = 0; k < 7; k++) begin
            rddata[(6-k)*32 +: 32] = mem[k][addr_d2];
        end
    end

    int checks = 0;
    int passed = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Sink-order image: sample i lives in bank i%7 at address i/7.
    task automatic loadPattern(input int offset);
        for (int i = 0; i < 7*256; i++) begin
            mem[i%7][i/7] = 32'(i + offset);
        end
    endtask

    typedef struct {
        int len;
        int offset;
        int expLastAddr;
        int expLastRden;
        int expDoneDelay;
        int expLat;
    } vec_t;

    int firstRden, firstValid, eopIter, doneIter, doneCnt;
    int nIss, nBeat, issErr, dataErr, lastAddr, lastRden;

    task automatic applyStimulus(input int len, input int offset);
        int prevValid;
        logic [6:0] expR;
        loadPattern(offset);
        fsm = 3'd0;
        frame_len = 12'(len);
        repeat (3) @(negedge clk);
        firstRden = -1; firstValid = -1; eopIter = 0; doneIter = 0; doneCnt = 0;
        nIss = 0; nBeat = 0; issErr = 0; dataErr = 0; lastAddr = 0; lastRden = 0;
        prevValid = 0;
        fsm = 3'd5;
        for (int j = 1; j <= len + 30; j++) begin
            @(negedge clk);
            if (rden != 7'd0) begin
                if (firstRden < 0) firstRden = j;
                expR = 7'b1000000 >> (nIss % 7);
                if (rden !== expR || rdaddr !== 8'(nIss / 7)) issErr++;
                lastRden = int'(rden);
                lastAddr = int'(rdaddr);
                nIss++;
            end
            if (out_valid) begin
                if (firstValid < 0) firstValid = j;
                if (nBeat > 0 && prevValid == 0) dataErr++;
                if (out_data !== 32'(nBeat + offset) || out_sop !== (nBeat == 0) ||
                    out_eop !== (nBeat == len - 1)) dataErr++;
                if (out_eop) eopIter = j;
                nBeat++;
            end
            if (source_done) begin
                doneCnt++;
                doneIter = j;
            end
            prevValid = int'(out_valid);
        end
        fsm = 3'd0;
    endtask

    function automatic int allOutputs();
        return int'({out_valid, out_sop, out_eop, source_done, overTime,
                     |rden, |rdaddr, |out_data});
    endfunction

    initial begin
        vec_t vecs [5];
        int cnt, stray, dn, first;

        vecs[0] = '{len: 7,    offset: 1, expLastAddr: 0,   expLastRden: 7'b0000001, expDoneDelay: 1, expLat: 3};
        vecs[1] = '{len: 1200, offset: 0, expLastAddr: 171, expLastRden: 7'b0010000, expDoneDelay: 1, expLat: 3};
        vecs[2] = '{len: 1,    offset: 1, expLastAddr: 0,   expLastRden: 7'b1000000, expDoneDelay: 1, expLat: 3};
        vecs[3] = '{len: 0,    offset: 1, expLastAddr: 0,   expLastRden: 0,          expDoneDelay: 2, expLat: 0};
        vecs[4] = '{len: 16,   offset: 1, expLastAddr: 2,   expLastRden: 7'b0100000, expDoneDelay: 1, expLat: 3};

        rst_n = 1'b0;
        fsm = 3'd0;
        frame_len = 12'd0;
        loadPattern(1);
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", allOutputs(), 0);
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            applyStimulus(vecs[v].len, vecs[v].offset);
            $display("[TB] frame_len=%0d issued=%0d beats=%0d", vecs[v].len, nIss, nBeat);
            checkOutput($sformatf("issues_len%0d", vecs[v].len), nIss, vecs[v].len);
            checkOutput($sformatf("issue_order_len%0d", vecs[v].len), issErr, 0);
            checkOutput($sformatf("beats_len%0d", vecs[v].len), nBeat, vecs[v].len);
            checkOutput($sformatf("data_flags_len%0d", vecs[v].len), dataErr, 0);
            checkOutput($sformatf("last_rdaddr_len%0d", vecs[v].len), lastAddr, vecs[v].expLastAddr);
            checkOutput($sformatf("last_rden_len%0d", vecs[v].len), lastRden, vecs[v].expLastRden);
            checkOutput($sformatf("latency_len%0d", vecs[v].len), firstValid - firstRden, vecs[v].expLat);
            checkOutput($sformatf("done_count_len%0d", vecs[v].len), doneCnt, 1);
            checkOutput($sformatf("done_delay_len%0d", vecs[v].len),
                        (vecs[v].len == 0) ? doneIter : doneIter - eopIter, vecs[v].expDoneDelay);
        end

        // Abort after 40 reads, then re-enter and expect a fresh start at address 0, bank 0.
        loadPattern(1);
        frame_len = 12'd100;
        repeat (3) @(negedge clk);
        fsm = 3'd5;
        cnt = 0;
        for (int j = 0; j < 200 && cnt < 40; j++) begin
            @(negedge clk);
            if (rden != 7'd0) cnt++;
        end
        checkOutput("abort_reached_40", cnt, 40);
        fsm = 3'd0;
        @(negedge clk);
        checkOutput("abort_rden_off", int'(rden), 0);
        stray = int'(out_valid);
        dn = int'(source_done);
        repeat (20) begin
            @(negedge clk);
            if (out_valid) stray++;
            if (source_done) dn++;
        end
        checkOutput("abort_no_valid", stray, 0);
        checkOutput("abort_no_done", dn, 0);
        fsm = 3'd5;
        first = 0;
        for (int j = 0; j < 10 && first == 0; j++) begin
            @(negedge clk);
            if (rden != 7'd0) begin
                first = 1;
                checkOutput("reentry_rdaddr", int'(rdaddr), 0);
                checkOutput("reentry_rden", int'(rden), 7'b1000000);
            end
        end
        checkOutput("reentry_started", first, 1);
        fsm = 3'd0;
        repeat (5) @(negedge clk);

        // Reset on the 50th beat while still in Source.
        fsm = 3'd5;
        cnt = 0;
        for (int j = 0; j < 200 && cnt < 50; j++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        checkOutput("reset_reached_50", cnt, 50);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midreset_outputs", allOutputs(), 0);
        rst_n = 1'b1;
        fsm = 3'd0;
        stray = 0;
        dn = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) stray++;
            if (source_done) dn++;
        end
        checkOutput("midreset_no_valid", stray, 0);
        checkOutput("midreset_no_done", dn, 0);

        // Timeout: entry cycle counts as cycle 1, so the pulse shows up 2048 edges later.
        frame_len = 12'd0;
        repeat (3) @(negedge clk);
        fsm = 3'd5;
        cnt = 0;
        first = -1;
        for (int j = 1; j <= 3000; j++) begin
            @(negedge clk);
            if (overTime) begin
                cnt++;
                if (first < 0) first = j;
            end
        end
        checkOutput("overtime_count", cnt, 1);
        checkOutput("overtime_cycle", first, 2048);
        fsm = 3'd0;
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
